// File: rtl/paddle_ctrl_if.sv
// Paddle controller bus: keypad command and run-enable in, position and status out.
interface paddle_ctrl_if;
    logic [3:0] control;
    logic       enable;
    logic [7:0] paddle_x;
    logic       moving;
    logic       at_left;
    logic       at_right;
    logic       step_tick;

    modport master (
        output control, enable,
        input  paddle_x, moving, at_left, at_right, step_tick
    );

    modport slave (
        input  control, enable,
        output paddle_x, moving, at_left, at_right, step_tick
    );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle position controller: debounced keypad command, IDLE/LEFT/RIGHT FSM, tick-paced clamped motion.
// Optional macro PADDLE_ACCEL_EN enables speed-2 acceleration to step 3 after 8 consecutive steps.
module paddle_ctrl #(
    parameter int unsigned FIELD_W  = 160,
    parameter int unsigned PADDLE_W = 32,
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic         clock,
    input  logic         reset,
    paddle_ctrl_if.slave bus
);
    localparam int unsigned CW     = $clog2(TICK_DIV);
    localparam logic [7:0]  XMAX   = 8'(FIELD_W - PADDLE_W);
    localparam logic [7:0]  X_HOME = 8'((FIELD_W - PADDLE_W) / 2);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t        r_state, w_state_next;
    logic [3:0]    r_ctl_prev, r_cmd_q;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_x, w_x_next;
    logic [8:0]    w_sum;
    logic [1:0]    r_step, w_step_next;
    logic          w_spd2;
    logic          w_tick;
    logic          r_moving, r_at_left, r_at_right;
`ifdef PADDLE_ACCEL_EN
    logic [3:0]    r_run;
`endif

    assign w_tick = bus.enable && (r_cnt == CW'(TICK_DIV - 1));

    // FSM process 1: state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // FSM process 2: next state and step size from the debounced command
    always_comb begin
        w_state_next = IDLE;
        w_spd2       = 1'b0;
        case (r_cmd_q)
            4'b0001: w_state_next = RIGHT;
            4'b0011: begin w_state_next = RIGHT; w_spd2 = 1'b1; end
            4'b0100: w_state_next = LEFT;
            4'b0110: begin w_state_next = LEFT;  w_spd2 = 1'b1; end
            default: w_state_next = IDLE;
        endcase
`ifdef PADDLE_ACCEL_EN
        w_step_next = !w_spd2 ? 2'd1 : ((r_run == 4'd8) ? 2'd3 : 2'd2);
`else
        w_step_next = w_spd2 ? 2'd2 : 2'd1;
`endif
    end

    // FSM process 3: position update, clamped at both edges
    always_comb begin
        w_sum    = {1'b0, r_x} + {7'b0, r_step};
        w_x_next = r_x;
        if (w_tick) begin
            case (r_state)
                LEFT:    w_x_next = (r_x < {6'b0, r_step}) ? '0 : r_x - {6'b0, r_step};
                RIGHT:   w_x_next = (w_sum > {1'b0, XMAX}) ? XMAX : w_sum[7:0];
                default: w_x_next = r_x;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ctl_prev <= '1;
            r_cmd_q    <= '1;
            r_cnt      <= '0;
            r_x        <= X_HOME;
            r_step     <= 2'd1;
            r_moving   <= 1'b0;
            r_at_left  <= 1'b0;
            r_at_right <= 1'b0;
        end else begin
            r_ctl_prev <= bus.control;
            if (bus.control == r_ctl_prev) r_cmd_q <= bus.control;
            if (bus.enable) r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            r_x        <= w_x_next;
            r_step     <= w_step_next;
            r_moving   <= (w_state_next != IDLE);
            r_at_left  <= (w_x_next == 8'd0);
            r_at_right <= (w_x_next == XMAX);
        end
    end

`ifdef PADDLE_ACCEL_EN
    // Run length of uninterrupted speed-2 steps in one direction
    always_ff @(posedge clock) begin
        if (reset)
            r_run <= '0;
        else if (w_state_next == IDLE || w_state_next != r_state || !w_spd2)
            r_run <= '0;
        else if (w_tick && r_state != IDLE && r_step != 2'd1 && r_run != 4'd8)
            r_run <= r_run + 4'd1;
    end
`endif

    assign bus.paddle_x  = r_x;
    assign bus.moving    = r_moving;
    assign bus.at_left   = r_at_left;
    assign bus.at_right  = r_at_right;
    assign bus.step_tick = w_tick;
endmodule
